if_fetch_stage: RTL and testbench

//   Instruction-fetch stage of the RV32IM pipeline. Owns the PC register and drives the

---
 rtl/if_fetch_stage_if.sv | 44 ++++
 rtl/if_fetch_stage.sv | 108 ++++++++++
 tb/tb_if_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Bus bundle for the instruction-fetch stage. It carries the ROM address and data,
// the hazard and redirect controls, and the IF/ID pipeline register outputs.
// The master modport is the fetch stage. The slave modport is the surrounding pipeline.
interface if_fetch_stage_if;
    logic [12:0] rom_pc;
    logic [31:0] rom_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        misalign;
    logic        halted;
    logic [31:0] fetch_cnt;

    modport master (
        output rom_pc,
        input  rom_instr,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output if_id_valid,
        output if_id_pc,
        output if_id_instr,
        output misalign,
        output halted,
        output fetch_cnt
    );

    modport slave (
        input  rom_pc,
        output rom_instr,
        output stall,
        output redirect,
        output redirect_pc,
        input  if_id_valid,
        input  if_id_pc,
        input  if_id_instr,
        input  misalign,
        input  halted,
        input  fetch_cnt
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the RV32IM pipeline. It owns the PC and drives the
// combinational ROM address, then captures ROM data into the IF/ID register.
// It also handles stall, branch/jump redirect and halt-on-EBREAK.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] EBREAK    = 32'h0010_0073
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        if_id_valid_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_instr_q;
    logic        misalign_q;
    logic        halted_q;
    logic [31:0] fetch_cnt_q;
    logic [31:0] redirect_pc_d;

    // Redirect target with the low two bits dropped, so the PC always stays word aligned.
    always_comb begin
        redirect_pc_d = {bus.redirect_pc[31:2], 2'b00};
    end

    // Fetch FSM. Handles the PC, the IF/ID register, the misalign pulse, the halt flag and the fetch counter.
    // NOTE: every state register uses non-blocking assignments, so all of them see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= 32'h0;
            if_id_instr_q <= NOP_INSTR;
            misalign_q    <= 1'b0;
            halted_q      <= 1'b0;
            fetch_cnt_q   <= 32'h0;
        end else begin
            // misalign is a single-cycle pulse. It is cleared here and raised only by a redirect below.
            misalign_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    // The ROM output for RESET_PC is not trusted on the first cycle, so this cycle only idles.
                    state_q <= RUN;
                end
                RUN: begin
                    if (bus.redirect) begin
                        pc_q          <= redirect_pc_d;
                        if_id_valid_q <= 1'b0;
                        if_id_pc_q    <= 32'h0;
                        if_id_instr_q <= NOP_INSTR;
                        misalign_q    <= |bus.redirect_pc[1:0];
                    end else if (!bus.stall) begin
                        if_id_valid_q <= 1'b1;
                        if_id_pc_q    <= pc_q;
                        if_id_instr_q <= bus.rom_instr;
                        fetch_cnt_q   <= fetch_cnt_q + 32'd1;
                        if (bus.rom_instr == EBREAK) begin
                            // The PC stays on the EBREAK, so a later redirect is the only way forward.
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end
                end
                HALT: begin
                    if (bus.redirect) begin
                        // A taken branch older than the EBREAK cancels the halt.
                        pc_q          <= redirect_pc_d;
                        if_id_valid_q <= 1'b0;
                        if_id_pc_q    <= 32'h0;
                        if_id_instr_q <= NOP_INSTR;
                        misalign_q    <= |bus.redirect_pc[1:0];
                        state_q       <= RUN;
                        halted_q      <= 1'b0;
                    end else if (!bus.stall) begin
                        if_id_valid_q <= 1'b0;
                        if_id_pc_q    <= 32'h0;
                        if_id_instr_q <= NOP_INSTR;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_pc      = pc_q[12:0];
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.misalign    = misalign_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage. It runs directed scenarios, then a randomized
// run that is compared every cycle against a behavioural model of fetch.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBK = 32'h0010_0073;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] rom [0:2047];

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_instr = rom[bus.rom_pc[12:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: the architectural fetch state.
    logic        m_boot;
    logic        m_halt;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_mis;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_ipc   = 32'h0;
        m_instr = NOP;
        m_mis   = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_bubble();
        m_valid = 1'b0;
        m_ipc   = 32'h0;
        m_instr = NOP;
    endtask

    // Applies one clock worth of the fetch rules to the model.
    task automatic model_update(input logic s, input logic r, input logic [31:0] rp);
        logic [31:0] word;
        m_mis = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (r) begin
            m_pc   = rp & ~32'd3;
            model_bubble();
            m_mis  = (rp % 4) != 0;
            m_halt = 1'b0;
        end else if (s) begin
            // nothing moves
        end else if (m_halt) begin
            model_bubble();
        end else begin
            word    = rom[(m_pc % 8192) / 4];
            m_valid = 1'b1;
            m_ipc   = m_pc;
            m_instr = word;
            m_cnt   = m_cnt + 1;
            if (word == EBK) m_halt = 1'b1;
            else             m_pc   = m_pc + 4;
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        bus.stall       = s;
        bus.redirect    = r;
        bus.redirect_pc = rp;
        model_update(s, r, rp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < 2048; i++) rom[i] = NOP;
        rom[0] = 32'h0050_0093;
        rom[1] = 32'h0010_0113;
        rom[2] = 32'h0020_81b3;
        rom[3] = 32'h0000_0013;
        rom[4] = 32'h0000_0013;
        rom[5] = EBK;
        rom[8] = 32'h1234_5678;
        rom[16] = 32'h00a0_0513;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        #3;
        n_checks++;
        if ({bus.if_id_valid, bus.misalign, bus.halted} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus.if_id_valid, bus.misalign, bus.halted});
        end
        n_checks++;
        if (bus.if_id_instr !== NOP || bus.if_id_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_ifid: got pc=%h instr=%h expected pc=0 instr=%h", bus.if_id_pc, bus.if_id_instr, NOP);
        end
        n_checks++;
        if (bus.rom_pc !== 13'h0 || bus.fetch_cnt !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_pc_cnt: got rom_pc=%h cnt=%0d expected 0/0", bus.rom_pc, bus.fetch_cnt);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] exp_instr [4];
        exp_instr = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81b3, 32'h0000_0013};
        do_reset();
        step(1'b0, 1'b1, 32'h80);   // BOOT must ignore this redirect
        n_checks++;
        if (bus.if_id_valid !== 1'b0 || bus.rom_pc !== 13'h0 || bus.misalign !== 1'b0) begin
            n_errors++;
            $display("FAIL boot_cycle: got valid=%b rom_pc=%h mis=%b expected 0/0/0", bus.if_id_valid, bus.rom_pc, bus.misalign);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0);
            n_checks++;
            if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'(i * 4) || bus.if_id_instr !== exp_instr[i]) begin
                n_errors++;
                $display("FAIL seq_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, i * 4, exp_instr[i]);
            end
        end
        n_checks++;
        if (bus.fetch_cnt !== 32'd4 || bus.rom_pc !== 13'h10) begin
            n_errors++;
            $display("FAIL seq_cnt: got cnt=%0d rom_pc=%h expected 4/0010", bus.fetch_cnt, bus.rom_pc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            n_checks++;
            if (bus.rom_pc !== 13'h8 || bus.if_id_pc !== 32'h4 || bus.if_id_instr !== 32'h0010_0113 || bus.fetch_cnt !== 32'd2) begin
                n_errors++;
                $display("FAIL stall_%0d: got rom_pc=%h if_pc=%h instr=%h cnt=%0d expected 0008/4/00100113/2",
                         i, bus.rom_pc, bus.if_id_pc, bus.if_id_instr, bus.fetch_cnt);
            end
        end
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.if_id_pc !== 32'h8 || bus.fetch_cnt !== 32'd3) begin
            n_errors++;
            $display("FAIL stall_resume: got if_pc=%h cnt=%0d expected 8/3", bus.if_id_pc, bus.fetch_cnt);
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h40);
        n_checks++;
        if (bus.rom_pc !== 13'h40 || bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP || bus.if_id_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL redir_stall: got rom_pc=%h v=%b instr=%h pc=%h expected 0040/0/00000013/0",
                     bus.rom_pc, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc);
        end
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.if_id_pc !== 32'h40 || bus.if_id_instr !== 32'h00a0_0513 || bus.if_id_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL redir_follow: got pc=%h instr=%h v=%b expected 40/00a00513/1", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid);
        end
    endtask

    task automatic test_ebreak_halt();
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.if_id_instr !== EBK || bus.if_id_pc !== 32'h14 || bus.halted !== 1'b1 || bus.rom_pc !== 13'h14 || bus.fetch_cnt !== 32'd6) begin
            n_errors++;
            $display("FAIL ebreak_latch: got instr=%h pc=%h halted=%b rom_pc=%h cnt=%0d expected 00100073/14/1/0014/6",
                     bus.if_id_instr, bus.if_id_pc, bus.halted, bus.rom_pc, bus.fetch_cnt);
        end
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (bus.if_id_instr !== EBK || bus.if_id_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_stall_hold: got instr=%h v=%b expected 00100073/1", bus.if_id_instr, bus.if_id_valid);
        end
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP || bus.halted !== 1'b1 || bus.rom_pc !== 13'h14 || bus.fetch_cnt !== 32'd6) begin
            n_errors++;
            $display("FAIL halt_bubble: got v=%b instr=%h halted=%b rom_pc=%h cnt=%0d expected 0/00000013/1/0014/6",
                     bus.if_id_valid, bus.if_id_instr, bus.halted, bus.rom_pc, bus.fetch_cnt);
        end
        step(1'b0, 1'b1, 32'h20);
        n_checks++;
        if (bus.halted !== 1'b0 || bus.rom_pc !== 13'h20 || bus.if_id_valid !== 1'b0 || bus.misalign !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_exit: got halted=%b rom_pc=%h v=%b mis=%b expected 0/0020/0/0",
                     bus.halted, bus.rom_pc, bus.if_id_valid, bus.misalign);
        end
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.if_id_pc !== 32'h20 || bus.if_id_instr !== 32'h1234_5678 || bus.rom_pc !== 13'h24) begin
            n_errors++;
            $display("FAIL halt_resume: got pc=%h instr=%h rom_pc=%h expected 20/12345678/0024", bus.if_id_pc, bus.if_id_instr, bus.rom_pc);
        end
    endtask

    task automatic test_misalign();
        step(1'b0, 1'b1, 32'h22);
        n_checks++;
        if (bus.misalign !== 1'b1 || bus.rom_pc !== 13'h20) begin
            n_errors++;
            $display("FAIL misalign_pulse: got mis=%b rom_pc=%h expected 1/0020", bus.misalign, bus.rom_pc);
        end
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.misalign !== 1'b0 || bus.if_id_pc !== 32'h20) begin
            n_errors++;
            $display("FAIL misalign_clear: got mis=%b if_pc=%h expected 0/20", bus.misalign, bus.if_id_pc);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.rom_pc !== 13'h0 || bus.if_id_valid !== 1'b0 || bus.fetch_cnt !== 32'h0 || bus.if_id_instr !== NOP || bus.halted !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got rom_pc=%h v=%b cnt=%0d instr=%h halted=%b expected 0/0/0/00000013/0",
                     bus.rom_pc, bus.if_id_valid, bus.fetch_cnt, bus.if_id_instr, bus.halted);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.if_id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL async_boot: got v=%b expected 0", bus.if_id_valid);
        end
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.if_id_pc !== 32'h0 || bus.if_id_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL async_first: got pc=%h v=%b expected 0/1", bus.if_id_pc, bus.if_id_valid);
        end
    endtask

    task automatic test_random();
        logic        s;
        logic        r;
        logic [31:0] rp;
        for (int i = 0; i < 2048; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? EBK : $urandom();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            s  = ($urandom_range(0, 9) < 3);
            r  = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 2047)) * 4;
            step(s, r, rp);
            n_checks++;
            if (bus.rom_pc !== m_pc[12:0]) begin
                n_errors++;
                $display("FAIL rnd_rom_pc c=%0d: got %h expected %h", c, bus.rom_pc, m_pc[12:0]);
            end
            n_checks++;
            if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_instr} !== {m_valid, m_ipc, m_instr}) begin
                n_errors++;
                $display("FAIL rnd_ifid c=%0d: got v=%b pc=%h instr=%h expected v=%b pc=%h instr=%h",
                         c, bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, m_valid, m_ipc, m_instr);
            end
            n_checks++;
            if ({bus.misalign, bus.halted} !== {m_mis, m_halt} || bus.fetch_cnt !== m_cnt) begin
                n_errors++;
                $display("FAIL rnd_status c=%0d: got mis=%b halted=%b cnt=%0d expected mis=%b halted=%b cnt=%0d",
                         c, bus.misalign, bus.halted, bus.fetch_cnt, m_mis, m_halt, m_cnt);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        load_program();
        test_reset();
        test_sequence();
        test_stall();
        test_redirect_stall();
        test_ebreak_halt();
        test_misalign();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
